// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Round-robin arbiter and access sequencer that shares one single-port data
// memory between two requesters. Requester 0 is the sensor sampler (mostly
// writes) and requester 1 is the radio packetizer (mostly reads). Only one
// access is in flight at a time. The granted requester's command is latched at
// grant time, so later changes on its inputs have no effect on that access.
//
// Ports
//   clk            system clock, all state updates on the rising edge
//   rst_n          asynchronous active-low reset
//   req0/req1      access request, held high until the matching ack
//   we0/we1        1 = write, 0 = read
//   addr0/addr1    access address
//   wdata0/wdata1  write data
//   ack0/ack1      one-cycle completion pulse to the granted requester
//   rdata0/rdata1  last read result per requester, held until its next read
//   busy           high whenever an access is in progress (state != IDLE)
//   mem_addr       memory address pins (0 while idle)
//   mem_data_in    memory write-data pins (0 while idle)
//   mem_write      memory write strobe, one cycle per write
//   mem_read       memory read strobe, one cycle per read
//   mem_data_out   memory read data, registered inside the memory
//
// Every output is decoded from registered state only, so no combinational
// path runs from the request inputs to any output.
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    RWAIT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  grant_q, grant_d;          // owner of the current access
  logic                  last_grant_q, last_grant_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

  // Requester picked in IDLE: under contention the one not served last wins,
  // otherwise whichever single requester is asking.
  logic pick;
  assign pick = (req0 && req1) ? ~last_grant_q : req1;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;   // requester 0 wins the first contention
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and latch logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant_d = pick;
          we_d    = pick ? we1    : we0;
          addr_d  = pick ? addr1  : addr0;
          wdata_d = pick ? wdata1 : wdata0;
          state_d = (pick ? we1 : we0) ? WR : RD;
        end
      end
      WR: begin
        state_d = DONE;
      end
      RD: begin
        state_d = RWAIT;
      end
      RWAIT: begin
        // Memory output is valid the cycle after the read strobe.
        if (grant_q) begin
          rdata1_d = mem_data_out;
        end else begin
          rdata0_d = mem_data_out;
        end
        state_d = DONE;
      end
      DONE: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from registered state
  // ---------------------------------------------------------------------------
  always_comb begin
    busy        = (state_q != IDLE);
    mem_write   = (state_q == WR);
    mem_read    = (state_q == RD);
    mem_addr    = (state_q != IDLE) ? addr_q  : '0;
    mem_data_in = (state_q != IDLE) ? wdata_q : '0;
    ack0        = (state_q == DONE) && !grant_q;
    ack1        = (state_q == DONE) &&  grant_q;
    rdata0      = rdata0_q;
    rdata1      = rdata1_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed plus randomized bench for mem_arbiter. A simple registered-read
// memory sits on the arbiter's memory pins. Expected behaviour comes from a
// reference model of the memory contents, each requester's last read result
// and the round-robin rule "under contention, serve whoever was not served
// last"; cycle positions follow the documented write/read latencies.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int NW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic          we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, busy, mem_write, mem_read;
  logic [DW-1:0] rdata0, rdata1, mem_data_in;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_out;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [DW-1:0] ref_mem [NW];
  logic [DW-1:0] exp_rd0 = '0;
  logic [DW-1:0] exp_rd1 = '0;
  int            last_served = 1;

  always #5 clk = ~clk;

  // Data memory attached to the arbiter: registered read, synchronous write.
  logic [DW-1:0] mem_arr [NW];
  always @(posedge clk) begin
    if (mem_write) mem_arr[mem_addr] <= mem_data_in;
    if (mem_read)  mem_data_out      <= mem_arr[mem_addr];
  end

  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0         (req0),
    .req1         (req1),
    .we0          (we0),
    .we1          (we1),
    .addr0        (addr0),
    .addr1        (addr1),
    .wdata0       (wdata0),
    .wdata1       (wdata1),
    .ack0         (ack0),
    .ack1         (ack1),
    .rdata0       (rdata0),
    .rdata1       (rdata1),
    .busy         (busy),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_write    (mem_write),
    .mem_read     (mem_read),
    .mem_data_out (mem_data_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    if (r == 0) begin
      we0 = we; addr0 = a; wdata0 = d; req0 = 1'b1;
    end else begin
      we1 = we; addr1 = a; wdata1 = d; req1 = 1'b1;
    end
  endtask

  task automatic drop_req(input int r);
    if (r == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  // Scramble the granted requester's command; the access must not notice.
  task automatic perturb(input int r);
    if (r == 0) begin
      we0 = 1'($urandom); addr0 = AW'($urandom); wdata0 = DW'($urandom);
    end else begin
      we1 = 1'($urandom); addr1 = AW'($urandom); wdata1 = DW'($urandom);
    end
  endtask

  // Follows one access from the sampling edge to the IDLE cycle afterwards.
  // Call while the arbiter is idle and before the edge that grants requester r.
  task automatic serve(input int r, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    logic [1:0] want_ack;
    want_ack = (r == 0) ? 2'b01 : 2'b10;
    @(posedge clk); #1;
    chk("grant_busy", 32'(busy), 32'd1);
    chk("grant_mem_write", 32'(mem_write), 32'(we));
    chk("grant_mem_read", 32'(mem_read), 32'(!we));
    chk("grant_mem_addr", 32'(mem_addr), 32'(a));
    if (we) chk("grant_mem_data_in", 32'(mem_data_in), 32'(d));
    chk("grant_no_ack", 32'({ack1, ack0}), 32'd0);
    perturb(r);
    #1;
    chk("stable_mem_addr", 32'(mem_addr), 32'(a));
    if (we) begin
      ref_mem[a] = d;
    end else begin
      @(posedge clk); #1;
      chk("rwait_strobes", 32'({mem_write, mem_read}), 32'd0);
      chk("rwait_no_ack", 32'({ack1, ack0}), 32'd0);
      chk("rwait_mem_addr", 32'(mem_addr), 32'(a));
      if (r == 0) exp_rd0 = ref_mem[a];
      else        exp_rd1 = ref_mem[a];
    end
    @(posedge clk); #1;
    chk("done_ack", 32'({ack1, ack0}), 32'(want_ack));
    chk("done_strobes", 32'({mem_write, mem_read}), 32'd0);
    chk("done_rdata0", 32'(rdata0), 32'(exp_rd0));
    chk("done_rdata1", 32'(rdata1), 32'(exp_rd1));
    drop_req(r);
    last_served = r;
    @(posedge clk); #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_no_ack", 32'({ack1, ack0}), 32'd0);
    chk("idle_mem_addr", 32'(mem_addr), 32'd0);
    chk("idle_mem_data_in", 32'(mem_data_in), 32'd0);
  endtask

  // Both requesters raise a request in the same cycle.
  task automatic contend(input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    int first;
    set_req(0, w0, a0, d0);
    set_req(1, w1, a1, d1);
    first = (last_served == 1) ? 0 : 1;
    if (first == 0) begin
      serve(0, w0, a0, d0);
      serve(1, w1, a1, d1);
    end else begin
      serve(1, w1, a1, d1);
      serve(0, w0, a0, d0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    // Reset held with a write pending from requester 0.
    set_req(0, 1'b1, 4'd3, 8'h5A);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'({ack1, ack0}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobes", 32'({mem_write, mem_read}), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_data_in", 32'(mem_data_in), 32'd0);
    chk("rst_rdata", 32'({rdata1, rdata0}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single write then read-back from the other requester.
    serve(0, 1'b1, 4'd3, 8'h5A);
    set_req(1, 1'b0, 4'd3, 8'h00);
    serve(1, 1'b0, 4'd3, 8'h00);

    // Full sweep: writes of 2*i, then reads with a wrap back to address 0.
    for (int i = 0; i < NW; i++) begin
      set_req(0, 1'b1, AW'(i), DW'(2 * i));
      serve(0, 1'b1, AW'(i), DW'(2 * i));
    end
    for (int i = 0; i <= NW; i++) begin
      set_req(1, 1'b0, AW'(i), DW'($urandom));
      serve(1, 1'b0, AW'(i), 8'h00);
    end

    // Contention rounds with random commands; grants must alternate.
    for (int i = 0; i < 16; i++) begin
      contend(1'($urandom), AW'($urandom), DW'($urandom),
              1'($urandom), AW'($urandom), DW'($urandom));
    end

    // Random single-requester traffic.
    for (int i = 0; i < 20; i++) begin
      int            r;
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      r = int'($urandom_range(1, 0));
      w = 1'($urandom);
      a = AW'($urandom);
      d = DW'($urandom);
      set_req(r, w, a, d);
      serve(r, w, a, d);
    end

    // Reset in the middle of a read: strobe drops at once, no ack follows.
    set_req(1, 1'b0, 4'd5, 8'h00);
    @(posedge clk); #1;
    chk("mid_rd_strobe", 32'(mem_read), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_read", 32'(mem_read), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ack", 32'({ack1, ack0}), 32'd0);
    chk("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_rdata", 32'({rdata1, rdata0}), 32'd0);
    drop_req(1);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_no_ack", 32'({ack1, ack0}), 32'd0);
    chk("mid_rst_idle", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_served = 1;
    exp_rd0 = '0;
    exp_rd1 = '0;

    // After reset requester 0 must again win the first contention.
    contend(1'b0, 4'd7, 8'h00, 1'b0, 4'd9, 8'h00);
    contend(1'b1, 4'd2, 8'hC3, 1'b0, 4'd2, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
